// File: rtl/debug_step_controller_pkg.sv
// Shared types for the debug step controller: step modes, command opcodes, burst length helper.
package debug_step_controller_pkg;

  typedef enum logic [1:0] {
    HALT        = 2'd0,
    FREE_RUN    = 2'd1,
    STEP_BUTTON = 2'd2,
    BURST       = 2'd3
  } step_mode_t;

  typedef enum logic [1:0] {
    OP_SET_MODE = 2'd0,
    OP_BURST    = 2'd1,
    OP_CLEAR    = 2'd2,
    OP_SINGLE   = 2'd3
  } step_opcode_t;

  localparam int unsigned BURST_ZERO_MEANS = 64;

  typedef logic [6:0] burst_cnt_t;

  // A burst length field of zero requests the maximum burst.
  function automatic burst_cnt_t burst_load(input logic [5:0] n);
    return (n == 6'd0) ? burst_cnt_t'(BURST_ZERO_MEANS) : burst_cnt_t'(n);
  endfunction

endpackage

// File: rtl/debug_step_controller_if.sv
// SPI command byte handshake feeding the debug step controller.
interface debug_step_controller_if;

  logic [7:0] cmd;
  logic       cmd_valid;

  modport master (output cmd, output cmd_valid);
  modport slave  (input  cmd, input  cmd_valid);

endinterface

// File: rtl/debug_step_controller_tick_divider.sv
// Free-running tick divider: pulses wrap in the cycle its count sits at DIV_COUNT-1 while running.
module debug_step_controller_tick_divider #(
  parameter int unsigned DIV_COUNT = 30000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic wrap
);

  localparam int unsigned CW = $clog2(DIV_COUNT);
  localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign wrap = run && !clear && (cnt == LAST);

endmodule

// File: rtl/debug_step_controller.sv
// Game-tick source and telemetry counter bank driven by SPI debug commands.
// Optional breakpoint-on-tick-count halt is enabled by defining DEBUG_STEP_BREAKPOINT_EN.
module debug_step_controller
  import debug_step_controller_pkg::*;
#(
  parameter int unsigned DIV_COUNT   = 30000000,
  parameter int unsigned NUM_EVENTS  = 3,
  parameter int unsigned VALUE_WIDTH = 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  debug_step_controller_if.slave                     spi,
  input  logic                                       step_btn,
  input  logic [NUM_EVENTS-1:0]                      events,
  output logic                                       game_tick,
  output logic [1:0]                                 mode,
  output logic                                       tick_led,
  output logic [NUM_EVENTS:0][VALUE_WIDTH-1:0]       telemetry_values
`ifdef DEBUG_STEP_BREAKPOINT_EN
  ,
  input  logic                                       bp_enable,
  input  logic [VALUE_WIDTH-1:0]                     bp_value,
  output logic                                       bp_hit
`endif
);

  step_mode_t   mode_q, mode_d;
  burst_cnt_t   burst_left, burst_d;
  step_opcode_t opcode;

  logic cmd_valid_q, step_btn_q;
  logic cmd_edge, btn_edge;
  logic op_set, op_burst, op_clear, op_single;
  logic mode_chg, run, wrap, single_ok, tick_req, bp_trip;

  logic [VALUE_WIDTH-1:0]                 tick_cnt, tick_nxt;
  logic [NUM_EVENTS-1:0][VALUE_WIDTH-1:0] evt_cnt, evt_nxt;

  assign cmd_edge  = spi.cmd_valid && !cmd_valid_q;
  assign opcode    = step_opcode_t'(spi.cmd[7:6]);
  assign op_set    = cmd_edge && (opcode == OP_SET_MODE);
  assign op_burst  = cmd_edge && (opcode == OP_BURST);
  assign op_clear  = cmd_edge && (opcode == OP_CLEAR);
  assign op_single = cmd_edge && (opcode == OP_SINGLE);
  assign mode_chg  = op_set || op_burst;

  assign run       = (mode_q == FREE_RUN) || (mode_q == BURST);
  assign single_ok = op_single && ((mode_q == HALT) || (mode_q == STEP_BUTTON));
  assign btn_edge  = step_btn && !step_btn_q && (mode_q == STEP_BUTTON);
  // Back-to-back triggers collapse so game_tick never stays high two cycles.
  assign tick_req  = (wrap || single_ok || btn_edge) && !game_tick;

  debug_step_controller_tick_divider #(
    .DIV_COUNT (DIV_COUNT)
  ) u_divider (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clear (mode_chg),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid_q <= 1'b0;
      step_btn_q  <= 1'b0;
      game_tick   <= 1'b0;
      tick_led    <= 1'b0;
    end else begin
      cmd_valid_q <= spi.cmd_valid;
      step_btn_q  <= step_btn;
      game_tick   <= tick_req;
      if (game_tick) begin
        tick_led <= ~tick_led;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= HALT;
      burst_left <= '0;
    end else begin
      mode_q     <= mode_d;
      burst_left <= burst_d;
    end
  end

  // Commands take precedence over breakpoint and burst completion in the same cycle.
  always_comb begin
    mode_d  = mode_q;
    burst_d = burst_left;
    if (op_set) begin
      mode_d  = step_mode_t'(spi.cmd[1:0]);
      burst_d = (step_mode_t'(spi.cmd[1:0]) == BURST) ? burst_cnt_t'(1) : '0;
    end else if (op_burst) begin
      mode_d  = BURST;
      burst_d = burst_load(spi.cmd[5:0]);
    end else if (bp_trip) begin
      mode_d  = HALT;
      burst_d = '0;
    end else if ((mode_q == BURST) && wrap) begin
      if (burst_left <= burst_cnt_t'(1)) begin
        mode_d  = HALT;
        burst_d = '0;
      end else begin
        burst_d = burst_left - burst_cnt_t'(1);
      end
    end
  end

  always_comb begin
    tick_nxt = tick_cnt + {{(VALUE_WIDTH-1){1'b0}}, game_tick};
    evt_nxt  = evt_cnt;
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      evt_nxt[i] = evt_cnt[i] + {{(VALUE_WIDTH-1){1'b0}}, events[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || op_clear) begin
      tick_cnt         <= '0;
      evt_cnt          <= '0;
      telemetry_values <= '0;
    end else begin
      tick_cnt <= tick_nxt;
      evt_cnt  <= evt_nxt;
      if (game_tick) begin
        telemetry_values <= {evt_nxt, tick_nxt};
      end
    end
  end

`ifdef DEBUG_STEP_BREAKPOINT_EN
  assign bp_trip = bp_enable && game_tick && run && !op_clear && (tick_nxt == bp_value);

  always_ff @(posedge clk) begin
    if (reset || mode_chg) begin
      bp_hit <= 1'b0;
    end else if (bp_trip) begin
      bp_hit <= 1'b1;
    end
  end
`else
  assign bp_trip = 1'b0;
`endif

  assign mode = mode_q;

endmodule

// File: tb/tb_debug_step_controller.sv
// Directed bench for debug_step_controller: expected tick cycles go into a scoreboard queue as commands are driven.
module tb_debug_step_controller;

  localparam int unsigned DIV = 4;
  localparam int unsigned NE  = 2;
  localparam int unsigned VW  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic step_btn = 1'b0;
  logic [NE-1:0] events = '0;
  logic game_tick, tick_led;
  logic [1:0] mode;
  logic [NE:0][VW-1:0] telemetry_values;
`ifdef DEBUG_STEP_BREAKPOINT_EN
  logic bp_enable = 1'b0;
  logic [VW-1:0] bp_value = '0;
  logic bp_hit;
`endif

  debug_step_controller_if spi ();

  debug_step_controller #(
    .DIV_COUNT   (DIV),
    .NUM_EVENTS  (NE),
    .VALUE_WIDTH (VW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .spi              (spi),
    .step_btn         (step_btn),
    .events           (events),
    .game_tick        (game_tick),
    .mode             (mode),
    .tick_led         (tick_led),
    .telemetry_values (telemetry_values)
`ifdef DEBUG_STEP_BREAKPOINT_EN
    ,
    .bp_enable        (bp_enable),
    .bp_value         (bp_value),
    .bp_hit           (bp_hit)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_q[$];
  int mon_want;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every observed tick must match the next scheduled tick cycle.
  always @(negedge clk) begin
    if (!reset && game_tick) begin
      mon_want = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      check("tick_cycle", cyc, mon_want);
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) cyc_wait(1);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    spi.cmd = b;
    spi.cmd_valid = 1'b1;
    cyc_wait(1);
    spi.cmd_valid = 1'b0;
    cyc_wait(1);
  endtask

  task automatic push_ticks(input int first, input int n, input int period);
    for (int k = 0; k < n; k++) exp_q.push_back(first + k * period);
  endtask

  int c;

  initial begin
    spi.cmd = '0;
    spi.cmd_valid = 1'b0;
    cyc_wait(3);
    reset = 1'b0;
    cyc_wait(1);
    check("reset_tick", game_tick, 0);
    check("reset_mode", mode, 0);
    check("reset_led", tick_led, 0);
    check("reset_tel0", telemetry_values[0], 0);
    check("reset_tel1", telemetry_values[1], 0);
    check("reset_tel2", telemetry_values[2], 0);

    cyc_wait(20);
    check("idle_mode", mode, 0);
    check("idle_tel0", telemetry_values[0], 0);

    // Free run: 10 ticks, 4 cycles apart
    c = cyc;
    push_ticks(c + 5, 10, 4);
    send_cmd(8'h01);
    check("fr_mode", mode, 1);
    wait_until(c + 42);
    check("fr_tel0", telemetry_values[0], 10);
    check("fr_led", tick_led, 0);
    check("fr_pending", exp_q.size(), 0);
    send_cmd(8'h00);
    cyc_wait(8);
    check("halt_mode", mode, 0);

    // Burst of 3
    c = cyc;
    push_ticks(c + 5, 3, 4);
    send_cmd(8'h43);
    check("b3_mode", mode, 3);
    wait_until(c + 20);
    check("b3_mode_end", mode, 0);
    check("b3_tel0", telemetry_values[0], 13);
    check("b3_led", tick_led, 1);
    check("b3_pending", exp_q.size(), 0);

    // Burst length 0 means 64
    c = cyc;
    push_ticks(c + 5, 64, 4);
    send_cmd(8'h40);
    wait_until(c + 265);
    check("b64_mode_end", mode, 0);
    check("b64_tel0", telemetry_values[0], 77);
    check("b64_led", tick_led, 1);
    check("b64_pending", exp_q.size(), 0);

    // Mode change mid-burst abandons it
    c = cyc;
    push_ticks(c + 5, 2, 4);
    send_cmd(8'h45);
    wait_until(c + 10);
    send_cmd(8'h00);
    cyc_wait(10);
    check("abandon_mode", mode, 0);
    check("abandon_pending", exp_q.size(), 0);

    // SET_MODE to BURST gives a single paced tick
    c = cyc;
    push_ticks(c + 5, 1, 4);
    send_cmd(8'h03);
    wait_until(c + 15);
    check("setburst_mode", mode, 0);
    check("setburst_tel0", telemetry_values[0], 80);
    check("setburst_pending", exp_q.size(), 0);

    // CLEAR coincident with an event: clear wins
    spi.cmd = 8'h80;
    spi.cmd_valid = 1'b1;
    events = 2'b01;
    cyc_wait(1);
    spi.cmd_valid = 1'b0;
    events = 2'b00;
    cyc_wait(1);
    check("clear_tel0", telemetry_values[0], 0);
    c = cyc;
    push_ticks(c + 1, 1, 1);
    send_cmd(8'hC0);
    cyc_wait(1);
    check("clear_snap_tel0", telemetry_values[0], 1);
    check("clear_snap_tel1", telemetry_values[1], 0);
    check("clear_snap_tel2", telemetry_values[2], 0);
    check("clear_mode", mode, 0);

    // Event counting
    events = 2'b01;
    cyc_wait(1);
    events = 2'b11;
    cyc_wait(1);
    events = 2'b01;
    cyc_wait(1);
    events = 2'b00;
    c = cyc;
    push_ticks(c + 1, 1, 1);
    send_cmd(8'hC0);
    cyc_wait(1);
    check("evt_tel0", telemetry_values[0], 2);
    check("evt_tel1", telemetry_values[1], 3);
    check("evt_tel2", telemetry_values[2], 1);

    // cmd_valid held high: one tick only
    c = cyc;
    push_ticks(c + 1, 1, 1);
    spi.cmd = 8'hC0;
    spi.cmd_valid = 1'b1;
    cyc_wait(10);
    spi.cmd_valid = 1'b0;
    cyc_wait(3);
    check("hold_pending", exp_q.size(), 0);
    check("hold_tel0", telemetry_values[0], 3);

    // Step button: held level gives one tick; button + SINGLE together give one tick
    send_cmd(8'h02);
    check("step_mode", mode, 2);
    c = cyc;
    push_ticks(c + 1, 1, 1);
    step_btn = 1'b1;
    cyc_wait(50);
    step_btn = 1'b0;
    cyc_wait(2);
    check("btn_pending", exp_q.size(), 0);
    c = cyc;
    push_ticks(c + 1, 1, 1);
    step_btn = 1'b1;
    spi.cmd = 8'hC0;
    spi.cmd_valid = 1'b1;
    cyc_wait(1);
    spi.cmd_valid = 1'b0;
    cyc_wait(5);
    step_btn = 1'b0;
    cyc_wait(2);
    check("btn_single_pending", exp_q.size(), 0);
    check("btn_tel0", telemetry_values[0], 5);

    // Reset mid-burst
    c = cyc;
    push_ticks(c + 5, 1, 4);
    send_cmd(8'h4A);
    wait_until(c + 6);
    reset = 1'b1;
    cyc_wait(1);
    reset = 1'b0;
    cyc_wait(20);
    check("rst_mode", mode, 0);
    check("rst_tel0", telemetry_values[0], 0);
    check("rst_led", tick_led, 0);
    check("rst_pending", exp_q.size(), 0);

`ifdef DEBUG_STEP_BREAKPOINT_EN
    bp_enable = 1'b1;
    bp_value = 8'd5;
    check("bp_reset", bp_hit, 0);
    c = cyc;
    push_ticks(c + 5, 5, 4);
    send_cmd(8'h01);
    wait_until(c + 30);
    check("bp_mode", mode, 0);
    check("bp_hit", bp_hit, 1);
    check("bp_tel0", telemetry_values[0], 5);
    check("bp_pending", exp_q.size(), 0);
    send_cmd(8'h00);
    check("bp_cleared", bp_hit, 0);
    bp_enable = 1'b0;
`endif

    cyc_wait(5);
    check("final_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
